// File: rtl/fp_ftoi_if.sv
// Request/result bundle for the float-to-fixed converter.
// The master drives requests and the pipeline enable; the slave returns results.
interface fp_ftoi_if;
   logic        i_en;
   logic        i_valid;
   logic [21:0] i_a;
   logic        o_valid;
   logic [31:0] o_d;
   logic        o_ovf;

   modport master (
      output i_en, i_valid, i_a,
      input  o_valid, o_d, o_ovf
   );

   modport slave (
      input  i_en, i_valid, i_a,
      output o_valid, o_d, o_ovf
   );
endinterface

// File: rtl/fp_ftoi.sv
// Three-stage float (sign, 5-bit exponent, 16-bit explicit-one fraction) to
// signed 32-bit fixed-point converter with truncation and saturation.
module fp_ftoi #(
   parameter int P_FRAC = 16
) (
   input  logic     clk,
   input  logic     rst_x,
   fp_ftoi_if.slave bus
);

   // Value is f * 2^(e-30); scaling by 2^P_FRAC folds into one shift offset.
   localparam logic signed [6:0] SH_OFS = 7'(P_FRAC - 30);

   logic [4:0]         exp_in;
   logic [15:0]        frac_in;
   logic signed [6:0]  sh_in;
   logic               zero_in;
   logic               sat_in;

   logic               vld_p0, sign_p0, zero_p0, sat_p0;
   logic signed [6:0]  sh_p0;
   logic [15:0]        frac_p0;

   logic               vld_p1, sign_p1, sat_p1;
   logic [31:0]        mag_p1;

   logic               vld_p2, ovf_p2;
   logic signed [31:0] d_p2;

   function automatic logic [31:0] shift_mag(input logic [15:0] f,
                                             input logic signed [6:0] sh);
      logic [31:0] ext;
      logic [6:0]  rsh;
      ext = {16'h0000, f};
      rsh = 7'(-sh);
      if (sh >= 7'sd0)
         shift_mag = ext << sh[4:0];
      else if (rsh >= 7'd16)
         shift_mag = 32'h0000_0000;
      else
         shift_mag = ext >> rsh[3:0];
   endfunction

   // Negating the magnitude of -0 yields 0, so no special case is needed.
   function automatic logic signed [31:0] sat_neg(input logic s, input logic sat,
                                                  input logic [31:0] m);
      if (sat)
         sat_neg = s ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
      else if (s)
         sat_neg = $signed(~m + 32'd1);
      else
         sat_neg = $signed(m);
   endfunction

   assign exp_in  = bus.i_a[20:16];
   assign frac_in = bus.i_a[15:0];
   assign sh_in   = $signed({2'b00, exp_in}) + SH_OFS;
   assign zero_in = (exp_in == 5'd0);
   assign sat_in  = !zero_in && (sh_in >= 7'sd16);

   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         vld_p0  <= 1'b0;
         sign_p0 <= 1'b0;
         zero_p0 <= 1'b0;
         sat_p0  <= 1'b0;
         sh_p0   <= '0;
         frac_p0 <= '0;
         vld_p1  <= 1'b0;
         sign_p1 <= 1'b0;
         sat_p1  <= 1'b0;
         mag_p1  <= '0;
         vld_p2  <= 1'b0;
         ovf_p2  <= 1'b0;
         d_p2    <= '0;
      end else if (bus.i_en) begin
         // S1: decode
         vld_p0  <= bus.i_valid;
         sign_p0 <= bus.i_a[21];
         zero_p0 <= zero_in;
         sat_p0  <= sat_in;
         sh_p0   <= sh_in;
         frac_p0 <= frac_in;
         // S2: barrel shift to magnitude
         vld_p1  <= vld_p0;
         sign_p1 <= sign_p0;
         sat_p1  <= sat_p0;
         mag_p1  <= (zero_p0 || sat_p0) ? 32'h0000_0000 : shift_mag(frac_p0, sh_p0);
         // S3: negate / saturate into output registers
         vld_p2  <= vld_p1;
         ovf_p2  <= sat_p1;
         d_p2    <= sat_neg(sign_p1, sat_p1, mag_p1);
      end
   end

   assign bus.o_valid = vld_p2;
   assign bus.o_d     = d_p2;
   assign bus.o_ovf   = ovf_p2;

endmodule

// File: tb/tb_fp_ftoi.sv
// Scoreboard bench for fp_ftoi: directed vectors, stall, random traffic and
// mid-flight reset, with expected results queued as each input is accepted.
module tb_fp_ftoi;
   localparam int P_FRAC = 16;

   logic clk = 1'b0;
   logic rst_x;

   always #5 clk = ~clk;

   fp_ftoi_if bus ();

   fp_ftoi #(.P_FRAC(P_FRAC)) dut (
      .clk  (clk),
      .rst_x(rst_x),
      .bus  (bus)
   );

   typedef struct {
      logic [31:0] d;
      logic        ovf;
      int          stamp;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_err    = 0;
   int          en_cnt   = 0;
   logic        en_q     = 1'b0;
   logic [31:0] nxt_d    = '0;
   logic        nxt_ovf  = 1'b0;
   logic        last_vld = 1'b0;
   logic [31:0] last_d   = '0;
   logic        last_ovf = 1'b0;

   logic [21:0] dir_a   [10] = '{22'h0F8000, 22'h30A000, 22'h1DFFFF, 22'h1E8000, 22'h3F8000,
                                 22'h00FFFF, 22'h018000, 22'h0DC001, 22'h2DC001, 22'h20FFFF};
   logic [31:0] dir_d   [10] = '{32'h0001_0000, 32'hFFFD_8000, 32'h7FFF_8000, 32'h7FFF_FFFF,
                                 32'h8000_0000, 32'h0000_0000, 32'h0000_0004, 32'h0000_6000,
                                 32'hFFFF_A000, 32'h0000_0000};
   logic        dir_ovf [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference: value f * 2^(e-30) scaled by 2^P_FRAC, truncated toward zero.
   function automatic void model(input logic [21:0] a, output logic [31:0] d, output logic ovf);
      int     e;
      int     sh;
      longint f;
      longint m;
      e  = int'(a[20:16]);
      f  = longint'(a[15:0]);
      sh = e - 30 + P_FRAC;
      if (e == 0) begin
         d   = 32'h0;
         ovf = 1'b0;
      end else if (sh >= 16) begin
         d   = a[21] ? 32'h8000_0000 : 32'h7FFF_FFFF;
         ovf = 1'b1;
      end else begin
         if (sh >= 0) m = f * (longint'(1) << sh);
         else         m = f / (longint'(1) << (-sh));
         d   = a[21] ? 32'(-m) : 32'(m);
         ovf = 1'b0;
      end
   endfunction

   task automatic drive(input logic en, input logic vld, input logic [21:0] a,
                        input logic [31:0] ed, input logic eovf);
      @(negedge clk);
      bus.i_en    = en;
      bus.i_valid = vld;
      bus.i_a     = a;
      nxt_d       = ed;
      nxt_ovf     = eovf;
   endtask

   task automatic drive_m(input logic en, input logic vld, input logic [21:0] a);
      logic [31:0] ed;
      logic        eovf;
      model(a, ed, eovf);
      drive(en, vld, a, ed, eovf);
   endtask

   // Queue the expected result on the edge that accepts the input.
   always @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         en_q <= 1'b0;
      end else begin
         en_q <= bus.i_en;
         if (bus.i_en) begin
            en_cnt <= en_cnt + 1;
            if (bus.i_valid) sb.push_back('{nxt_d, nxt_ovf, en_cnt + 1});
         end
      end
   end

   // A result is due after the accepting edge plus two further enabled edges.
   always @(negedge clk) begin
      if (!rst_x) begin
         last_vld <= 1'b0;
      end else if (en_q) begin
         if (sb.size() > 0 && sb[0].stamp + 2 <= en_cnt) begin
            check("o_valid", 32'(bus.o_valid), 32'h1);
            check("o_d", bus.o_d, sb[0].d);
            check("o_ovf", 32'(bus.o_ovf), 32'(sb[0].ovf));
            last_vld <= 1'b1;
            last_d   <= sb[0].d;
            last_ovf <= sb[0].ovf;
            void'(sb.pop_front());
         end else begin
            check("idle_valid", 32'(bus.o_valid), 32'h0);
            last_vld <= 1'b0;
         end
      end else begin
         check("stall_valid", 32'(bus.o_valid), 32'(last_vld));
         if (last_vld) begin
            check("stall_d", bus.o_d, last_d);
            check("stall_ovf", 32'(bus.o_ovf), 32'(last_ovf));
         end
      end
   end

   initial begin
      rst_x       = 1'b0;
      bus.i_en    = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_a     = '0;

      repeat (2) @(negedge clk);
      check("rst_valid", 32'(bus.o_valid), 32'h0);
      check("rst_d", bus.o_d, 32'h0);
      check("rst_ovf", 32'(bus.o_ovf), 32'h0);
      @(negedge clk);
      rst_x = 1'b1;

      for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, dir_a[i], dir_d[i], dir_ovf[i]);
      repeat (5) drive(1'b1, 1'b0, 22'h0, 32'h0, 1'b0);

      drive_m(1'b1, 1'b1, 22'h0F8000);
      drive_m(1'b1, 1'b1, 22'h30A000);
      repeat (2) drive(1'b0, 1'b1, 22'h3FFFFF, 32'hDEAD_BEEF, 1'b1);
      drive_m(1'b1, 1'b1, 22'h1DFFFF);
      drive_m(1'b1, 1'b1, 22'h2DC001);
      repeat (5) drive(1'b1, 1'b0, 22'h0, 32'h0, 1'b0);

      for (int i = 0; i < 80; i++)
         drive_m(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 22'($urandom));
      repeat (5) drive(1'b1, 1'b0, 22'h0, 32'h0, 1'b0);

      drive_m(1'b1, 1'b1, 22'h0F8000);
      drive_m(1'b1, 1'b1, 22'h1E8000);
      drive_m(1'b1, 1'b1, 22'h30A000);
      @(posedge clk);
      #1;
      rst_x       = 1'b0;
      bus.i_valid = 1'b0;
      sb.delete();
      #1;
      check("flush_valid", 32'(bus.o_valid), 32'h0);
      check("flush_d", bus.o_d, 32'h0);
      check("flush_ovf", 32'(bus.o_ovf), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_x = 1'b1;
      repeat (6) drive(1'b1, 1'b0, 22'h0, 32'h0, 1'b0);
      drive_m(1'b1, 1'b1, 22'h3F8000);
      repeat (5) drive(1'b1, 1'b0, 22'h0, 32'h0, 1'b0);

      check("sb_empty", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
